// File: rtl/div_scheduler_pkg.sv
// Shared constants for the divider scheduler: state encoding, parameter
// defaults and the divide-by-zero result.
package div_scheduler_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int N_REQ_DEF   = 3;
  localparam int TIMEOUT_DEF = 40;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_scheduler_rr_arbiter.sv
// Round-robin selector: searches from the requester after last_ptr, wrapping.
module rr_arbiter
  import div_scheduler_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IW   = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_ptr,
  output logic [IW-1:0]    grant_idx,
  output logic             any
);

  logic [IW:0] cand;

  always_comb begin
    grant_idx = last_ptr;
    any       = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!any && req[cand[IW-1:0]]) begin
        any       = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// Shares one external divider among N_REQ requesters with round-robin grant,
// divide-by-zero bypass and a RUN timeout.
//
//  state | meaning
//  IDLE  | divider held in reset; arbitrate and latch winner operands
//  LOAD  | one cycle presenting latched operands with divider in reset
//  RUN   | divider enabled; wait for div_done or timeout
//  DONE  | one-cycle valid strobe to winner; advance last-grant pointer
module div_scheduler
  import div_scheduler_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] dividend_in,
  input  logic [32*N_REQ-1:0] divisor_in,
  output logic [31:0]         quotient,
  output logic [31:0]         remainder,
  output logic [N_REQ-1:0]    valid,
  output logic                err,
  output logic                busy,
  output logic                div_reset,
  output logic                div_start,
  output logic [31:0]         div_dividend,
  output logic [31:0]         div_divisor,
  input  logic [31:0]         div_quotient,
  input  logic [31:0]         div_remainder,
  input  logic                div_done
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] winner_q, winner_d;
  logic [IW-1:0] last_q, last_d;
  logic [31:0]   dvd_q, dvd_d;
  logic [31:0]   dvs_q, dvs_d;
  logic [31:0]   quot_q, quot_d;
  logic [31:0]   rem_q, rem_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic [31:0]   a_arr [N_REQ];
  logic [31:0]   b_arr [N_REQ];

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .last_ptr  (last_q),
    .grant_idx (gnt_idx),
    .any       (gnt_any)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr[i] = dividend_in[32*i +: 32];
      b_arr[i] = divisor_in[32*i +: 32];
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (gnt_any) begin
          winner_d = gnt_idx;
          dvd_d    = a_arr[gnt_idx];
          dvs_d    = b_arr[gnt_idx];
          // Zero divisor never reaches the divider.
          if (b_arr[gnt_idx] == 32'd0) begin
            quot_d  = DIV0_QUOT;
            rem_d   = a_arr[gnt_idx];
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (div_done) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          quot_d  = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = winner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      last_q   <= IW'(N_REQ - 1);
      dvd_q    <= '0;
      dvs_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    valid = '0;
    if (state_q == ST_DONE) valid[winner_q] = 1'b1;
  end

  assign quotient     = quot_q;
  assign remainder    = rem_q;
  assign err          = err_q;
  assign busy         = (state_q != ST_IDLE);
  assign div_reset    = (state_q != ST_RUN);
  assign div_start    = (state_q == ST_RUN);
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;

endmodule
